// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the req/ack handshake to
// instruction memory and presents one instruction per cycle to decode.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_wpcir,
  input  logic        cu_branch,
  input  logic [31:0] ID_new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READY,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nx;
  logic [31:0] redir_pc;
  logic [31:0] redir_pc_nx;
  logic [31:0] buf_inst;
  logic [31:0] buf_inst_nx;
  logic [3:0]  seq;
  logic [3:0]  seq_nx;
  logic        valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      redir_pc <= RESET_PC;
      buf_inst <= '0;
      seq      <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      redir_pc <= redir_pc_nx;
      buf_inst <= buf_inst_nx;
      seq      <= seq_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    redir_pc_nx = redir_pc;
    buf_inst_nx = buf_inst;
    seq_nx      = seq;
    imem_req    = 1'b0;
    if_inst     = '0;
    valid       = 1'b0;
    case (state)
      IDLE: begin
        state_nx = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // memory data bypasses straight to decode for zero-wait throughput
          if_inst = imem_rdata;
          valid   = 1'b1;
          if (cu_branch) begin
            fetch_pc_nx = ID_new_pc;
          end else if (!cu_wpcir) begin
            fetch_pc_nx = fetch_pc + 32'd4;
            seq_nx      = seq + 4'd1;
          end else begin
            buf_inst_nx = imem_rdata;
            state_nx    = READY;
          end
        end else if (cu_branch) begin
          redir_pc_nx = ID_new_pc;
          state_nx    = DRAIN;
        end
      end
      READY: begin
        if_inst = buf_inst;
        valid   = 1'b1;
        if (cu_branch) begin
          fetch_pc_nx = ID_new_pc;
          state_nx    = FETCH;
        end else if (!cu_wpcir) begin
          fetch_pc_nx = fetch_pc + 32'd4;
          seq_nx      = seq + 4'd1;
          state_nx    = FETCH;
        end
      end
      DRAIN: begin
        // the stale request must complete before the redirect target is fetched
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_pc_nx = cu_branch ? ID_new_pc : redir_pc;
          state_nx    = FETCH;
        end else if (cu_branch) begin
          redir_pc_nx = ID_new_pc;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign imem_addr     = fetch_pc;
  assign if_pc4        = fetch_pc + 32'd4;
  assign IF_ins_number = valid ? seq : 4'd0;

  always_comb begin
    IF_ins_type = 4'd0;
    if (if_inst != 32'd0) begin
      case (if_inst[31:26])
        6'h00:        IF_ins_type = 4'd1;
        6'h23:        IF_ins_type = 4'd2;
        6'h2B:        IF_ins_type = 4'd3;
        6'h04, 6'h05: IF_ins_type = 4'd4;
        6'h02, 6'h03: IF_ins_type = 4'd5;
        default:      IF_ins_type = 4'd6;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run
// against a program-order model with a variable-latency memory.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cu_wpcir = 1'b0;
  logic        cu_branch = 1'b0;
  logic [31:0] ID_new_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic [3:0]  IF_ins_type;
  logic [3:0]  IF_ins_number;

  int n_chk = 0;
  int n_fail = 0;

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .cu_wpcir(cu_wpcir),
    .cu_branch(cu_branch),
    .ID_new_pc(ID_new_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .if_inst(if_inst),
    .if_pc4(if_pc4),
    .IF_ins_type(IF_ins_type),
    .IF_ins_number(IF_ins_number)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Memory image: distinct per word address, never zero, mixes opcode kinds.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    case (a[4:2])
      3'd0: op = 6'h00;
      3'd1: op = 6'h23;
      3'd2: op = 6'h2B;
      3'd3: op = 6'h04;
      3'd4: op = 6'h02;
      3'd5: op = 6'h08;
      3'd6: op = 6'h05;
      default: op = 6'h03;
    endcase
    return {op, a[27:3], 1'b1};
  endfunction

  function automatic logic [3:0] ref_type(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (w == 32'd0) return 4'd0;
    if (op == 6'h00) return 4'd1;
    if (op == 6'h23) return 4'd2;
    if (op == 6'h2B) return 4'd3;
    if (op == 6'h04 || op == 6'h05) return 4'd4;
    if (op == 6'h02 || op == 6'h03) return 4'd5;
    return 4'd6;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    cu_wpcir = 1'b0;
    cu_branch = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fast(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cu_wpcir = 1'b0;
      cu_branch = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_inst !== 32'h0 ||
        if_pc4 !== 32'h4 || IF_ins_type !== 4'd0 || IF_ins_number !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: req=%b addr=%h inst=%h pc4=%h type=%0d num=%0d want 0/0/0/4/0/0",
               imem_req, imem_addr, if_inst, if_pc4, IF_ins_type, IF_ins_number);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (imem_req !== 1'b0 || if_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_gap: req=%b inst=%h want 0/0", imem_req, if_inst);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_ack = 1'b1;
      imem_rdata = mem_word(imem_addr);
      #1;
      n_chk++;
      if (imem_addr !== 32'(4 * i) || if_pc4 !== 32'(4 * i + 4) ||
          IF_ins_number !== 4'(i) || if_inst !== mem_word(32'(4 * i))) begin
        n_fail++;
        $display("FAIL zero_wait[%0d]: addr=%h pc4=%h num=%0d inst=%h want %h/%h/%0d/%h",
                 i, imem_addr, if_pc4, IF_ins_number, if_inst,
                 32'(4 * i), 32'(4 * i + 4), i, mem_word(32'(4 * i)));
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      n_chk++;
      if (if_inst !== 32'h0 || IF_ins_type !== 4'd0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
        n_fail++;
        $display("FAIL latency_wait[%0d]: inst=%h type=%0d req=%b addr=%h want 0/0/1/0",
                 i, if_inst, IF_ins_type, imem_req, imem_addr);
      end
    end
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = mem_word(32'h0);
    #1;
    n_chk++;
    if (if_inst !== mem_word(32'h0) || IF_ins_number !== 4'd0) begin
      n_fail++;
      $display("FAIL latency_data: inst=%h num=%0d want %h/0", if_inst, IF_ins_number, mem_word(32'h0));
    end
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'h8C22_0000;
    cu_wpcir = 1'b1;
    #1;
    n_chk++;
    if (if_inst !== 32'h8C22_0000 || IF_ins_type !== 4'd2) begin
      n_fail++;
      $display("FAIL stall_first: inst=%h type=%0d want 8c220000/2", if_inst, IF_ins_type);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 32'h1234_5678;
      cu_wpcir = (i == 0);
      #1;
      n_chk++;
      if (if_inst !== 32'h8C22_0000 || if_pc4 !== 32'h4 || IF_ins_number !== 4'd0 ||
          IF_ins_type !== 4'd2 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: inst=%h pc4=%h num=%0d type=%0d req=%b want 8c220000/4/0/2/0",
                 i, if_inst, if_pc4, IF_ins_number, IF_ins_type, imem_req);
      end
    end
    @(negedge clk);
    cu_wpcir = 1'b0;
    #1;
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL stall_resume: req=%b addr=%h want 1/4", imem_req, imem_addr);
    end
  endtask

  task automatic test_ready_branch();
    do_reset();
    fast(2);
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = mem_word(imem_addr);
    cu_wpcir = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    cu_wpcir = 1'b1;
    cu_branch = 1'b1;
    ID_new_pc = 32'h40;
    #1;
    n_chk++;
    if (imem_req !== 1'b0 || if_pc4 !== 32'hC || if_inst !== mem_word(32'h8)) begin
      n_fail++;
      $display("FAIL ready_state: req=%b pc4=%h inst=%h want 0/c/%h", imem_req, if_pc4, if_inst, mem_word(32'h8));
    end
    @(negedge clk);
    cu_branch = 1'b0;
    cu_wpcir = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = mem_word(imem_addr);
    #1;
    n_chk++;
    if (imem_addr !== 32'h40 || if_pc4 !== 32'h44 || IF_ins_number !== 4'd2 ||
        if_inst !== mem_word(32'h40)) begin
      n_fail++;
      $display("FAIL ready_branch: addr=%h pc4=%h num=%0d inst=%h want 40/44/2/%h",
               imem_addr, if_pc4, IF_ins_number, if_inst, mem_word(32'h40));
    end
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    fast(4);
    @(negedge clk);
    imem_ack = 1'b0;
    cu_branch = 1'b1;
    ID_new_pc = 32'h80;
    #1;
    n_chk++;
    if (imem_addr !== 32'h10 || imem_req !== 1'b1 || if_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL drain_start: addr=%h req=%b inst=%h want 10/1/0", imem_addr, imem_req, if_inst);
    end
    @(negedge clk);
    cu_branch = 1'b0;
    #1;
    n_chk++;
    if (imem_addr !== 32'h10 || imem_req !== 1'b1 || if_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL drain_hold: addr=%h req=%b inst=%h want 10/1/0", imem_addr, imem_req, if_inst);
    end
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = mem_word(32'h10);
    #1;
    n_chk++;
    if (imem_addr !== 32'h10 || if_inst !== 32'h0 || IF_ins_type !== 4'd0) begin
      n_fail++;
      $display("FAIL drain_drop: addr=%h inst=%h type=%0d want 10/0/0", imem_addr, if_inst, IF_ins_type);
    end
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = mem_word(imem_addr);
    #1;
    n_chk++;
    if (imem_addr !== 32'h80 || if_pc4 !== 32'h84 || IF_ins_number !== 4'd4 ||
        if_inst !== mem_word(32'h80)) begin
      n_fail++;
      $display("FAIL drain_target: addr=%h pc4=%h num=%0d inst=%h want 80/84/4/%h",
               imem_addr, if_pc4, IF_ins_number, if_inst, mem_word(32'h80));
    end
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    fast(8);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    n_chk++;
    if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: addr=%h req=%b want 20/1", imem_addr, imem_req);
    end
    #1;
    rst = 1'b1;
    #1;
    n_chk++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_inst !== 32'h0 ||
        if_pc4 !== 32'h4 || IF_ins_number !== 4'd0) begin
      n_fail++;
      $display("FAIL areset_now: req=%b addr=%h inst=%h pc4=%h num=%0d want 0/0/0/4/0",
               imem_req, imem_addr, if_inst, if_pc4, IF_ins_number);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_idle: req=%b want 0", imem_req);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL areset_refetch: req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  // Program-order model: the next instruction delivered comes from exp_pc,
  // which advances on consumption and jumps to the latest redirect target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [3:0]  exp_seq;
    logic        held;
    logic [31:0] held_inst;
    logic        pend;
    logic [31:0] pend_addr;
    logic        valid;
    int          wait_cnt;
    int          quiet;
    exp_pc = 32'h0;
    exp_seq = 4'd0;
    held = 1'b0;
    held_inst = '0;
    pend = 1'b0;
    pend_addr = '0;
    wait_cnt = -1;
    quiet = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (pend) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
          n_fail++;
          $display("FAIL rnd_proto cyc %0d: req=%b addr=%h want 1/%h", cyc, imem_req, imem_addr, pend_addr);
        end
      end
      if (imem_req) begin
        if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, 2));
        imem_ack = (wait_cnt == 0);
        wait_cnt = imem_ack ? -1 : wait_cnt - 1;
      end else begin
        imem_ack = 1'b0;
        wait_cnt = -1;
      end
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
      cu_branch = ($urandom_range(0, 6) == 0);
      ID_new_pc = $urandom & 32'h0000_0FFC;
      cu_wpcir = ($urandom_range(0, 2) == 0);
      pend = imem_req && !imem_ack;
      pend_addr = imem_addr;
      #1;
      valid = (if_inst !== 32'h0);
      if (held) begin
        n_chk++;
        if (if_inst !== held_inst || imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_hold cyc %0d: inst=%h req=%b want %h/0", cyc, if_inst, imem_req, held_inst);
        end
      end
      n_chk++;
      if (valid) begin
        if (if_inst !== mem_word(exp_pc) || if_pc4 !== exp_pc + 32'd4 ||
            IF_ins_number !== exp_seq || IF_ins_type !== ref_type(if_inst)) begin
          n_fail++;
          $display("FAIL rnd_deliver cyc %0d: inst=%h pc4=%h num=%0d type=%0d want %h/%h/%0d/%0d",
                   cyc, if_inst, if_pc4, IF_ins_number, IF_ins_type,
                   mem_word(exp_pc), exp_pc + 32'd4, exp_seq, ref_type(mem_word(exp_pc)));
        end
      end else if (IF_ins_type !== 4'd0) begin
        n_fail++;
        $display("FAIL rnd_bubble cyc %0d: type=%0d want 0", cyc, IF_ins_type);
      end
      if (cu_branch) begin
        exp_pc = ID_new_pc;
        held = 1'b0;
      end else if (valid && !cu_wpcir) begin
        exp_pc = exp_pc + 32'd4;
        exp_seq = exp_seq + 4'd1;
        held = 1'b0;
      end else if (valid) begin
        held = 1'b1;
        held_inst = if_inst;
      end else begin
        held = 1'b0;
      end
      quiet = valid ? 0 : quiet + 1;
      if (quiet > 30) begin
        n_chk++;
        n_fail++;
        $display("FAIL rnd_liveness cyc %0d: %0d cycles without delivery, limit 30", cyc, quiet);
        break;
      end
    end
    @(negedge clk);
    imem_ack = 1'b0;
    cu_branch = 1'b0;
    cu_wpcir = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_ready_branch();
    test_drain();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
